// File: rtl/cpu_ctrl_fsm_if.sv
// cpu_ctrl_fsm_if: signal bundle between the controller and the datapath/program memory.
interface cpu_ctrl_fsm_if #(
    parameter int DATA_WIDTH      = 8,
    parameter int MUX_SELECT_BITS = 2,
    parameter int PC_WIDTH        = 8,
    parameter int RF_ADDR_BITS    = 2
);
    logic                       start;
    logic [15:0]                instr;
    logic                       zero_flag;
    logic [PC_WIDTH-1:0]        pc;
    logic                       imem_re;
    logic [MUX_SELECT_BITS-1:0] mux_select;
    logic [DATA_WIDTH-1:0]      imm_out;
    logic [RF_ADDR_BITS-1:0]    rf_raddr;
    logic [RF_ADDR_BITS-1:0]    rf_waddr;
    logic                       rf_we;
    logic [DATA_WIDTH-1:0]      mem_addr;
    logic                       mem_re;
    logic                       mem_we;
    logic [1:0]                 alu_op;
    logic                       busy;
    logic                       halted;
    logic                       illegal;

    modport master (
        input  start, instr, zero_flag,
        output pc, imem_re, mux_select, imm_out, rf_raddr, rf_waddr, rf_we,
               mem_addr, mem_re, mem_we, alu_op, busy, halted, illegal
    );

    modport slave (
        output start, instr, zero_flag,
        input  pc, imem_re, mux_select, imm_out, rf_raddr, rf_waddr, rf_we,
               mem_addr, mem_re, mem_we, alu_op, busy, halted, illegal
    );
endinterface

// File: rtl/cpu_ctrl_fsm.sv
// cpu_ctrl_fsm: 4-cycle fetch/decode/execute/writeback controller for the 8-bit lab CPU.
module cpu_ctrl_fsm #(
    parameter int DATA_WIDTH      = 8,
    parameter int MUX_SELECT_BITS = 2,
    parameter int PC_WIDTH        = 8,
    parameter int RF_ADDR_BITS    = 2
) (
    input logic             clk,
    input logic             rst,
    cpu_ctrl_fsm_if.master  bus
);
    typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXECUTE, WRITEBACK, HALT} state_t;

    state_t                     state_q, state_d;
    logic [15:0]                ir_q, dec_ir;
    logic [3:0]                 op, dop;
    logic                       zf_q, jump, dec_d;
    logic [PC_WIDTH-1:0]        pc_q, pc_d;
    logic                       imem_re_q, rf_we_q, mem_re_q, mem_we_q;
    logic                       busy_q, halted_q, illegal_q;
    logic [MUX_SELECT_BITS-1:0] mux_q;
    logic [DATA_WIDTH-1:0]      imm_q, mem_addr_q;
    logic [RF_ADDR_BITS-1:0]    raddr_q, waddr_q;
    logic [1:0]                 alu_q;

    assign op     = ir_q[15:12];
    // Entering EXECUTE the IR is loaded on the same edge, so decode straight from instr then.
    assign dec_ir = state_q == DECODE ? bus.instr : ir_q;
    assign dop    = dec_ir[15:12];
    assign jump   = op == 4'h7 || (op == 4'h8 && zf_q);
    assign dec_d  = state_d == EXECUTE || state_d == WRITEBACK;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:      state_d = bus.start ? FETCH : IDLE;
            FETCH:     state_d = DECODE;
            DECODE:    state_d = EXECUTE;
            EXECUTE:   state_d = WRITEBACK;
            WRITEBACK: state_d = op == 4'hF ? HALT : FETCH;
            default:   state_d = HALT;
        endcase
        pc_d = pc_q;
        if (state_q == WRITEBACK && op != 4'hF)
            pc_d = jump ? PC_WIDTH'(ir_q[7:0]) : pc_q + PC_WIDTH'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            pc_q       <= '0;
            ir_q       <= '0;
            zf_q       <= 1'b0;
            imem_re_q  <= 1'b0;
            rf_we_q    <= 1'b0;
            mem_re_q   <= 1'b0;
            mem_we_q   <= 1'b0;
            busy_q     <= 1'b0;
            halted_q   <= 1'b0;
            illegal_q  <= 1'b0;
            mux_q      <= '0;
            imm_q      <= '0;
            mem_addr_q <= '0;
            raddr_q    <= '0;
            waddr_q    <= '0;
            alu_q      <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            if (state_q == DECODE) ir_q <= bus.instr;
            if (state_q == EXECUTE) zf_q <= bus.zero_flag;
            imem_re_q  <= state_d == FETCH;
            mem_re_q   <= state_d == EXECUTE && dop == 4'h2;
            mem_we_q   <= state_d == EXECUTE && dop == 4'h3;
            rf_we_q    <= state_d == WRITEBACK && (dop inside {4'h1, 4'h2, 4'h4, 4'h5, 4'h6});
            illegal_q  <= illegal_q || (state_d == EXECUTE && (dop inside {[4'h9:4'hE]}));
            busy_q     <= !(state_d == IDLE || state_d == HALT);
            halted_q   <= state_d == HALT;
            imm_q      <= dec_d ? DATA_WIDTH'(dec_ir[7:0]) : '0;
            mem_addr_q <= dec_d ? DATA_WIDTH'(dec_ir[7:0]) : '0;
            raddr_q    <= dec_d ? RF_ADDR_BITS'(dec_ir[9:8]) : '0;
            waddr_q    <= dec_d ? RF_ADDR_BITS'(dec_ir[11:10]) : '0;
            mux_q      <= !dec_d ? '0 : dop == 4'h1 ? MUX_SELECT_BITS'(2) :
                          dop == 4'h2 ? MUX_SELECT_BITS'(1) : '0;
            alu_q      <= !dec_d ? 2'b00 : dop == 4'h5 ? 2'b01 : dop == 4'h6 ? 2'b10 : 2'b00;
        end
    end

    assign bus.pc         = pc_q;
    assign bus.imem_re    = imem_re_q;
    assign bus.mux_select = mux_q;
    assign bus.imm_out    = imm_q;
    assign bus.rf_raddr   = raddr_q;
    assign bus.rf_waddr   = waddr_q;
    assign bus.rf_we      = rf_we_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_re     = mem_re_q;
    assign bus.mem_we     = mem_we_q;
    assign bus.alu_op     = alu_q;
    assign bus.busy       = busy_q;
    assign bus.halted     = halted_q;
    assign bus.illegal    = illegal_q;
endmodule
